frame_sync_switcher: RTL and testbench
======================================

FRAME_SYNC_SWITCHER -- requirements
Module: frame_sync_switcher

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be supported:
- NUM_FUNC, 4: number of function sources; legal range 2..8.
- ADDR_W, 22: display address width.
- COLOR_W, 3: pixel colour width.
- SRC_LAT, 1: cycles from func_addr to the matching func_color; legal range 1..4.
- SEL_W, $clog2(NUM_FUNC): selector width.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- func_req, in, SEL_W: requested function index.
- func_req_valid, in, 1: request strobe.
- frame_start, in, 1: one-cycle pulse at the first cycle of a frame.
- display_en, in, 1: active-video qualifier for display_addr.
- display_addr, in, ADDR_W: pixel address from the timing generator.
- func_addr, out, ADDR_W: registered address broadcast to all sources.
- func_sel, out, NUM_FUNC: one-hot read enable for the active source.
- func_color, in, NUM_FUNC*COLOR_W: packed source colours; source i occupies bits [i*COLOR_W +: COLOR_W].
- display_color, out, COLOR_W: final pixel colour.
- active_func, out, SEL_W: currently applied function.
- switch_pending, out, 1: a request is waiting for frame_start.
- req_err, out, 1: one-cycle pulse when an out-of-range request is rejected.

Function
REQ-003 The block SHALL hold an applied selector (active_func) and a pending register (valid bit plus index).

REQ-004 A func_req_valid with func_req < NUM_FUNC SHALL load pending, set switch_pending the next cycle, and overwrite any earlier pending request.

REQ-005 A func_req_valid with func_req >= NUM_FUNC SHALL leave pending unchanged and pulse req_err high for exactly 1 cycle.

REQ-006 On frame_start with pending valid, active_func SHALL take the pending index the next cycle and switch_pending SHALL clear.

REQ-007 If frame_start and a valid in-range request occur in the same cycle, that request SHALL be applied at this frame_start.

REQ-008 If frame_start occurs with no pending request, active_func SHALL remain unchanged.

REQ-009 active_func SHALL never change other than on frame_start, so no mid-frame source switch is possible.

REQ-010 func_addr SHALL equal display_addr registered once, a latency of 1 cycle.

REQ-011 func_sel SHALL be the one-hot decode of active_func ANDed with display_en, registered alongside func_addr.

REQ-012 The selector and display_en SHALL be carried through a delay line of SRC_LAT stages aligned with func_color; the selector used for each pixel is the one in effect when its address was issued.

REQ-013 display_color SHALL be registered, and SHALL equal the delayed selector's slice of func_color when the delayed display_en is 1, otherwise 0.

REQ-014 Total latency from display_addr to display_color SHALL be SRC_LAT+2 cycles.

REQ-015 Pixels already in flight at a switch SHALL complete with the old source; the first pixel issued after the switch SHALL use the new source.

REQ-016 The block SHALL have no combinational path from any input to any output.

Reset
REQ-017 While rst is high at a clk edge, the block SHALL drive active_func=0, clear pending, switch_pending=0, req_err=0, func_addr=0, func_sel=0, display_color=0, and clear all delay-line stages.

REQ-018 Reset SHALL take priority over frame_start, func_req_valid and all data inputs in the same cycle.

REQ-019 A reset asserted mid-frame or with a request pending SHALL discard the pending request.

REQ-020 After rst deasserts, display_color SHALL stay 0 until valid pixels have propagated through the SRC_LAT+2 pipeline.

Verification
REQ-021 Defaults. Stimulus: reset, then display_en=1, display_addr=5, func_color slice0=3'b101. Response: func_addr=5 after 1 cycle; display_color=3'b101 after 3 cycles; active_func=0.

REQ-022 Frame-boundary switch. Stimulus: func_req=2 mid-frame. Response: switch_pending=1 and active_func stays 0 until frame_start; active_func=2 the cycle after frame_start; pixels issued before the switch still show source 0.

REQ-023 Same-cycle request. Stimulus: func_req=1 in the same cycle as frame_start. Response: active_func=1 the next cycle; switch_pending never asserts.

REQ-024 Overwrite then bad index. Stimulus: func_req=3, then func_req=1, then func_req=5 (NUM_FUNC=4), then frame_start. Response: req_err pulses once for the index-5 request; active_func=1.

REQ-025 Blanking. Stimulus: display_en=0 with a nonzero func_color. Response: display_color=0 and func_sel=0.

REQ-026 Reset mid-operation. Stimulus: pending request plus rst pulse, then frame_start. Response: all outputs 0 during reset; active_func stays 0 after frame_start.

Source files
------------

// File: rtl/frame_sync_switcher.sv
// Frame-synchronous function-source switcher: applies source requests only at
// frame_start and returns the chosen source's pixel colour with fixed latency.
module frame_sync_switcher #(
  parameter int unsigned NUM_FUNC = 4,
  parameter int unsigned ADDR_W   = 22,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SRC_LAT  = 1,
  parameter int unsigned SEL_W    = $clog2(NUM_FUNC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              func_req,
  input  logic                          func_req_valid,
  input  logic                          frame_start,
  input  logic                          display_en,
  input  logic [ADDR_W-1:0]             display_addr,
  output logic [ADDR_W-1:0]             func_addr,
  output logic [NUM_FUNC-1:0]           func_sel,
  input  logic [NUM_FUNC*COLOR_W-1:0]   func_color,
  output logic [COLOR_W-1:0]            display_color,
  output logic [SEL_W-1:0]              active_func,
  output logic                          switch_pending,
  output logic                          req_err
);

  localparam int unsigned DEPTH = SRC_LAT + 1;

  logic [SEL_W-1:0]    pend_idx;
  logic                req_ok_c;
  logic [NUM_FUNC-1:0] onehot_c;
  logic [COLOR_W-1:0]  color_c;
  logic [SEL_W-1:0]    sel_q [DEPTH];
  logic [DEPTH-1:0]    en_q;

  assign req_ok_c = func_req_valid && (32'(func_req) < NUM_FUNC);

  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < int'(NUM_FUNC); i++) begin
      onehot_c[i] = (active_func == SEL_W'(i));
    end
  end

  // Colour mux driven by the selector that travelled with the pixel address.
  always_comb begin
    color_c = '0;
    for (int i = 0; i < int'(NUM_FUNC); i++) begin
      if (sel_q[SRC_LAT] == SEL_W'(i)) begin
        color_c = func_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Request/apply control; a request arriving with frame_start wins over pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_func    <= '0;
      pend_idx       <= '0;
      switch_pending <= 1'b0;
      req_err        <= 1'b0;
    end else begin
      req_err <= func_req_valid && !req_ok_c;
      if (frame_start) begin
        if (req_ok_c) begin
          active_func <= func_req;
        end else if (switch_pending) begin
          active_func <= pend_idx;
        end
        switch_pending <= 1'b0;
      end else if (req_ok_c) begin
        pend_idx       <= func_req;
        switch_pending <= 1'b1;
      end
    end
  end

  // Address broadcast and selector/enable delay line aligned to func_color.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_addr     <= '0;
      func_sel      <= '0;
      display_color <= '0;
      en_q          <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        sel_q[k] <= '0;
      end
    end else begin
      func_addr <= display_addr;
      func_sel  <= display_en ? onehot_c : '0;
      sel_q[0]  <= active_func;
      en_q[0]   <= display_en;
      for (int k = 1; k < int'(DEPTH); k++) begin
        sel_q[k] <= sel_q[k-1];
        en_q[k]  <= en_q[k-1];
      end
      display_color <= en_q[SRC_LAT] ? color_c : '0;
    end
  end

endmodule

// File: tb/tb_frame_sync_switcher.sv
// Directed bench for frame_sync_switcher: stimulus pushes time-stamped
// expectations into a scoreboard, a negedge monitor compares them.
module tb_frame_sync_switcher;

  localparam int unsigned NUM_FUNC = 4;
  localparam int unsigned ADDR_W   = 22;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned SRC_LAT  = 1;
  localparam int unsigned SEL_W    = 3;
  localparam int          LAT      = SRC_LAT + 2;

  localparam int K_ADDR = 0, K_SEL = 1, K_COLOR = 2, K_ACT = 3, K_PEND = 4, K_ERR = 5;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [SEL_W-1:0]            func_req = '0;
  logic                        func_req_valid = 1'b0;
  logic                        frame_start = 1'b0;
  logic                        display_en = 1'b0;
  logic [ADDR_W-1:0]           display_addr = '0;
  logic [ADDR_W-1:0]           func_addr;
  logic [NUM_FUNC-1:0]         func_sel;
  logic [NUM_FUNC*COLOR_W-1:0] func_color = '0;
  logic [COLOR_W-1:0]          display_color;
  logic [SEL_W-1:0]            active_func;
  logic                        switch_pending;
  logic                        req_err;

  frame_sync_switcher #(
    .NUM_FUNC(NUM_FUNC), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
    .SRC_LAT(SRC_LAT), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .func_req(func_req), .func_req_valid(func_req_valid),
    .frame_start(frame_start), .display_en(display_en), .display_addr(display_addr),
    .func_addr(func_addr), .func_sel(func_sel), .func_color(func_color),
    .display_color(display_color), .active_func(active_func),
    .switch_pending(switch_pending), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Source model: one registered stage, source i returns (addr + i) mod 8.
  always @(posedge clk) begin
    for (int i = 0; i < int'(NUM_FUNC); i++) begin
      func_color[i*COLOR_W +: COLOR_W] <= COLOR_W'(func_addr + ADDR_W'(i));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int exp;
  } chk_t;

  chk_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  string kname [6] = '{"func_addr", "func_sel", "display_color", "active_func",
                       "switch_pending", "req_err"};

  function automatic int actual(input int kind);
    case (kind)
      K_ADDR:  return int'(func_addr);
      K_SEL:   return int'(func_sel);
      K_COLOR: return int'(display_color);
      K_ACT:   return int'(active_func);
      K_PEND:  return int'(switch_pending);
      default: return int'(req_err);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        vectors++;
        if (actual(sb[i].kind) !== sb[i].exp) begin
          miscompares++;
          $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                   kname[sb[i].kind], cyc, actual(sb[i].kind), sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL stale_%s cyc=%0d actual=unchecked required=%0d",
                 kname[sb[i].kind], sb[i].cyc, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int at, input int kind, input int exp);
    chk_t c;
    c.cyc  = at;
    c.kind = kind;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  // One pixel cycle; src is the source that should be in effect for this pixel.
  task automatic step(input bit en, input int addr, input bit fs, input bit rv,
                      input int req, input int src);
    @(posedge clk); #1;
    rst            = 1'b0;
    display_en     = en;
    display_addr   = ADDR_W'(addr);
    frame_start    = fs;
    func_req_valid = rv;
    func_req       = SEL_W'(req);
    push(cyc + 1, K_ADDR, addr);
    push(cyc + 1, K_SEL, en ? (1 << src) : 0);
    push(cyc + LAT, K_COLOR, en ? ((addr + src) & 7) : 0);
  endtask

  task automatic expect_next(input int kind, input int exp);
    push(cyc + 1, kind, exp);
  endtask

  // Reset with every other input active to show reset priority.
  task automatic do_reset(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      rst            = 1'b1;
      display_en     = 1'b1;
      display_addr   = ADDR_W'(99);
      frame_start    = 1'b1;
      func_req_valid = 1'b1;
      func_req       = SEL_W'(2);
      for (int kd = 0; kd < 6; kd++) push(cyc + 1, kd, 0);
    end
    push(cyc + 2, K_COLOR, 0);
    push(cyc + 3, K_COLOR, 0);
  endtask

  initial begin
    do_reset(2);

    // Defaults: source 0, addr 5 -> colour 5
    step(1, 5, 0, 0, 0, 0);  expect_next(K_ACT, 0);
    step(1, 10, 0, 0, 0, 0);

    // Mid-frame request for 2, applied at frame_start
    step(1, 20, 0, 1, 2, 0); expect_next(K_PEND, 1); expect_next(K_ACT, 0);
    step(1, 21, 0, 0, 0, 0); expect_next(K_PEND, 1); expect_next(K_ACT, 0);
    step(1, 22, 1, 0, 0, 0); expect_next(K_ACT, 2);  expect_next(K_PEND, 0);
    step(1, 23, 0, 0, 0, 2);

    // Request coinciding with frame_start applies immediately
    step(1, 30, 1, 1, 3, 2); expect_next(K_ACT, 3);  expect_next(K_PEND, 0);
    step(1, 31, 0, 0, 0, 3); expect_next(K_PEND, 0);

    // Overwrite 3 with 1, then out-of-range 5 is rejected
    step(1, 40, 0, 1, 3, 3); expect_next(K_PEND, 1);
    step(1, 41, 0, 1, 1, 3); expect_next(K_ERR, 0);
    step(1, 42, 0, 1, 5, 3); expect_next(K_ERR, 1);
    step(1, 43, 0, 0, 0, 3); expect_next(K_ERR, 0);  expect_next(K_PEND, 1);
    step(1, 44, 1, 0, 0, 3); expect_next(K_ACT, 1);  expect_next(K_ERR, 0);
    step(1, 45, 0, 0, 0, 1);

    // Blanking
    step(0, 50, 0, 0, 0, 1);
    step(0, 51, 0, 0, 0, 1);
    step(1, 52, 0, 0, 0, 1);

    // Pending request discarded by reset; frame_start afterwards has no effect
    step(1, 60, 0, 1, 2, 1); expect_next(K_PEND, 1);
    step(0, 61, 0, 0, 0, 1);
    step(0, 62, 0, 0, 0, 1);
    do_reset(2);
    step(1, 70, 1, 0, 0, 0); expect_next(K_ACT, 0);  expect_next(K_PEND, 0);
    step(1, 71, 0, 0, 0, 0); expect_next(K_ACT, 0);
    step(0, 72, 0, 0, 0, 0);

    repeat (LAT + 3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
